heartbeat_monitor: RTL and testbench

Receive-side checker for the periodic single-cycle heartbeat pulse produced by the heartbeat generator. It measures the interval between rising edges of the incoming heartbeat and checks it against the nominal period of 2^N cycles within a tolerance window. It reports lock, early and late (missing) beats, and keeps a saturating error count. It sits in the clock domain of the monitored logic, typically next to a watchdog or status register block.

---
 rtl/heartbeat_monitor_pkg.sv | 23 ++
 rtl/heartbeat_monitor_if.sv | 24 ++
 rtl/heartbeat_monitor_incr.sv | 12 +
 rtl/heartbeat_monitor.sv | 172 +++++++++++++++++
 tb/tb_heartbeat_monitor.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/heartbeat_monitor_pkg.sv
// Shared types and period-window helpers for the heartbeat receive-side checker.
package heartbeat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    ALARM  = 2'd3
  } hb_state_e;

  function automatic int nominal_period(input int n);
    return 1 << n;
  endfunction

  function automatic int lower_bound(input int n, input int tol);
    return nominal_period(n) - tol;
  endfunction

  function automatic int upper_bound(input int n, input int tol);
    return nominal_period(n) + tol;
  endfunction

endpackage

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat input, error clear and status outputs bundled between a driver and the monitor.
interface heartbeat_monitor_if #(
  parameter int ERRW = 8
) ();

  logic            hb_in;
  logic            clear_err;
  logic            locked;
  logic            alarm;
  logic            early;
  logic            late;
  logic [ERRW-1:0] err_count;

  modport master (
    output hb_in, clear_err,
    input  locked, alarm, early, late, err_count
  );

  modport slave (
    input  hb_in, clear_err,
    output locked, alarm, early, late, err_count
  );

endinterface

// File: rtl/heartbeat_monitor_incr.sv
// Plain W-bit incrementer; carry_o flags wrap so callers can saturate.
module heartbeat_monitor_incr #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o,
  output logic         carry_o
);

  assign {carry_o, y_o} = {1'b0, a_i} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/heartbeat_monitor.sv
// Measures heartbeat edge spacing against 2^N +/- TOL and reports lock, early/late and errors.
// HEARTBEAT_MONITOR_ERRCNT_EN builds the saturating err_count; otherwise err_count is 0.
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int N    = 8,
  parameter int TOL  = 2,
  parameter int LOCK = 4,
  parameter int ERRW = 8
) (
  input  logic               clk,
  input  logic               reset,
  heartbeat_monitor_if.slave hb
);

  localparam int W  = N + 1;
  localparam int GW = $clog2(LOCK + 1);

  localparam logic [W-1:0]  LO_C   = W'(lower_bound(N, TOL));
  localparam logic [W-1:0]  HI_C   = W'(upper_bound(N, TOL));
  localparam logic [W-1:0]  TO_C   = W'(upper_bound(N, TOL) + 1);
  localparam logic [GW-1:0] LOCK_C = GW'(LOCK);

  hb_state_e     state_q, state_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic          cnt_carry;
  logic          hb_q;
  logic          hb_edge;
  logic          is_good, is_early, timeout;
  logic          early_d, late_d;
  logic          early_q, late_q, locked_q, alarm_q;

  assign hb_edge = hb.hb_in & ~hb_q;

  heartbeat_monitor_incr #(.W(W)) u_incr (
    .a_i     (cnt_q),
    .y_o     (cnt_inc),
    .carry_o (cnt_carry)
  );

  // cnt holds the measured period at an edge and sticks at all-ones between beats
  always_comb begin
    cnt_d = cnt_inc;
    if (hb_edge) begin
      cnt_d = W'(1);
    end else if (cnt_carry) begin
      cnt_d = cnt_q;
    end
  end

  assign is_good  = (cnt_q >= LO_C) && (cnt_q <= HI_C);
  assign is_early = (cnt_q < LO_C);
  assign timeout  = !hb_edge && (cnt_q == TO_C);
  assign good_inc = good_q + GW'(1);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    early_d = 1'b0;
    late_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hb_edge) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      ACQ: begin
        if (hb_edge) begin
          if (is_good) begin
            good_d = good_inc;
            if (good_inc == LOCK_C) state_d = LOCKED;
          end else if (is_early) begin
            early_d = 1'b1;
            good_d  = '0;
          end else begin
            // edge landing exactly on the timeout cycle is still a late beat
            late_d  = 1'b1;
            state_d = ALARM;
          end
        end else if (timeout) begin
          late_d  = 1'b1;
          state_d = ALARM;
        end
      end
      LOCKED: begin
        if (hb_edge) begin
          if (is_early) begin
            early_d = 1'b1;
            good_d  = '0;
            state_d = ACQ;
          end else if (!is_good) begin
            late_d  = 1'b1;
            state_d = ALARM;
          end
        end else if (timeout) begin
          late_d  = 1'b1;
          state_d = ALARM;
        end
      end
      ALARM: begin
        if (hb_edge) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      good_q   <= '0;
      cnt_q    <= '0;
      hb_q     <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      locked_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      cnt_q    <= cnt_d;
      hb_q     <= hb.hb_in;
      early_q  <= early_d;
      late_q   <= late_d;
      locked_q <= (state_d == LOCKED);
      alarm_q  <= (state_d == ALARM);
    end
  end

  assign hb.early  = early_q;
  assign hb.late   = late_q;
  assign hb.locked = locked_q;
  assign hb.alarm  = alarm_q;

`ifdef HEARTBEAT_MONITOR_ERRCNT_EN
  logic [ERRW-1:0] err_q, err_d;
  logic            err_event;

  assign err_event = early_d | late_d;

  always_comb begin
    err_d = err_q;
    if (hb.clear_err) begin
      err_d = err_event ? ERRW'(1) : '0;
    end else if (err_event && (err_q != '1)) begin
      err_d = err_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign hb.err_count = err_q;
`else
  logic unused_clear_err;
  assign unused_clear_err = hb.clear_err;
  assign hb.err_count     = ERRW'(0);
`endif

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench: N=8 instance for lock/tolerance/timeout/reset, N=4 instance for err_count rules.
module tb_heartbeat_monitor;

`ifdef HEARTBEAT_MONITOR_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst8, rst4;
  int   checks = 0;
  int   failures = 0;
  int   early8_n = 0, late8_n = 0, early4_n = 0, late4_n = 0;

  always #5 clk = ~clk;

  heartbeat_monitor_if #(.ERRW(8)) if8 ();
  heartbeat_monitor_if #(.ERRW(4)) if4 ();

  heartbeat_monitor #(.N(8), .TOL(2), .LOCK(4), .ERRW(8)) dut8 (
    .clk(clk), .reset(rst8), .hb(if8)
  );
  heartbeat_monitor #(.N(4), .TOL(1), .LOCK(2), .ERRW(4)) dut4 (
    .clk(clk), .reset(rst4), .hb(if4)
  );

  always @(negedge clk) begin
    if (if8.early) early8_n++;
    if (if8.late)  late8_n++;
    if (if4.early) early4_n++;
    if (if4.late)  late4_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat8();
    if8.hb_in = 1'b1;
    tick();
    if8.hb_in = 1'b0;
  endtask

  task automatic period8(input int p);
    repeat (p - 1) tick();
    beat8();
  endtask

  task automatic beat4();
    if4.hb_in = 1'b1;
    tick();
    if4.hb_in = 1'b0;
  endtask

  task automatic period4(input int p);
    repeat (p - 1) tick();
    beat4();
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst4 = 1'b1;
    if8.hb_in = 1'b0; if8.clear_err = 1'b0;
    if4.hb_in = 1'b0; if4.clear_err = 1'b0;
    repeat (3) tick();
    checks++; if ({if8.locked, if8.alarm, if8.early, if8.late} !== 4'b0000) begin failures++; $display("FAIL reset_flags8 got=%b exp=0000", {if8.locked, if8.alarm, if8.early, if8.late}); end
    checks++; if (if8.err_count !== 8'd0) begin failures++; $display("FAIL reset_err8 got=%0d exp=0", if8.err_count); end
    rst8 = 1'b0; rst4 = 1'b0;
    tick();
    checks++; if ({if4.locked, if4.alarm, if4.early, if4.late, if4.err_count} !== 8'd0) begin failures++; $display("FAIL reset_all4 got=%b exp=0", {if4.locked, if4.alarm, if4.early, if4.late, if4.err_count}); end
  endtask

  task automatic test_lock();
    int e0, l0;
    e0 = early8_n; l0 = late8_n;
    beat8();
    checks++; if (if8.locked !== 1'b0) begin failures++; $display("FAIL lock_edge1 locked=%0b exp=0", if8.locked); end
    for (int i = 1; i <= 4; i++) begin
      period8(256);
      if (i == 3) begin
        checks++; if (if8.locked !== 1'b0) begin failures++; $display("FAIL lock_edge4 locked=%0b exp=0", if8.locked); end
      end
    end
    checks++; if (if8.locked !== 1'b1) begin failures++; $display("FAIL lock_edge5 locked=%0b exp=1", if8.locked); end
    checks++; if ((early8_n - e0) !== 0 || (late8_n - l0) !== 0) begin failures++; $display("FAIL lock_pulses early=%0d late=%0d exp=0/0", early8_n - e0, late8_n - l0); end
    checks++; if (if8.err_count !== 8'd0) begin failures++; $display("FAIL lock_err got=%0d exp=0", if8.err_count); end
  endtask

  task automatic test_tolerance();
    int e0;
    e0 = early8_n;
    period8(254);
    checks++; if (if8.locked !== 1'b1) begin failures++; $display("FAIL tol_254 locked=%0b exp=1", if8.locked); end
    period8(258);
    checks++; if (if8.locked !== 1'b1 || early8_n != e0) begin failures++; $display("FAIL tol_258 locked=%0b earlies=%0d exp=1/0", if8.locked, early8_n - e0); end
    period8(253);
    checks++; if (if8.early !== 1'b1 || if8.locked !== 1'b0) begin failures++; $display("FAIL tol_253 early=%0b locked=%0b exp=1/0", if8.early, if8.locked); end
    checks++; if (if8.err_count !== (ERR_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL tol_253_err got=%0d exp=%0d", if8.err_count, ERR_EN ? 1 : 0); end
    tick();
    checks++; if (if8.early !== 1'b0) begin failures++; $display("FAIL tol_early_width early=%0b exp=0", if8.early); end
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) period8(255); else period8(256);
      if (i == 3) begin
        checks++; if (if8.locked !== 1'b0) begin failures++; $display("FAIL relock_3 locked=%0b exp=0", if8.locked); end
      end
    end
    checks++; if (if8.locked !== 1'b1) begin failures++; $display("FAIL relock_4 locked=%0b exp=1", if8.locked); end
  endtask

  task automatic test_missing_beat();
    int l0;
    l0 = late8_n;
    repeat (258) tick();
    checks++; if (if8.late !== 1'b0 || if8.alarm !== 1'b0) begin failures++; $display("FAIL miss_258 late=%0b alarm=%0b exp=0/0", if8.late, if8.alarm); end
    tick();
    checks++; if (if8.late !== 1'b1 || if8.alarm !== 1'b1 || if8.locked !== 1'b0) begin failures++; $display("FAIL miss_259 late=%0b alarm=%0b locked=%0b exp=1/1/0", if8.late, if8.alarm, if8.locked); end
    checks++; if (if8.err_count !== (ERR_EN ? 8'd2 : 8'd0)) begin failures++; $display("FAIL miss_err got=%0d exp=%0d", if8.err_count, ERR_EN ? 2 : 0); end
    repeat (600) tick();
    checks++; if ((late8_n - l0) !== 1) begin failures++; $display("FAIL miss_single late_pulses=%0d exp=1", late8_n - l0); end
    beat8();
    checks++; if (if8.alarm !== 1'b0 || if8.locked !== 1'b0) begin failures++; $display("FAIL miss_resume alarm=%0b locked=%0b exp=0/0", if8.alarm, if8.locked); end
  endtask

  task automatic test_reset_mid();
    int e0, l0;
    repeat (4) period8(256);
    checks++; if (if8.locked !== 1'b1) begin failures++; $display("FAIL rmid_locked locked=%0b exp=1", if8.locked); end
    repeat (100) tick();
    #2 rst8 = 1'b1;
    #1;
    checks++; if ({if8.locked, if8.alarm, if8.early, if8.late, if8.err_count} !== 12'd0) begin failures++; $display("FAIL rmid_async got=%b exp=0", {if8.locked, if8.alarm, if8.early, if8.late, if8.err_count}); end
    tick();
    rst8 = 1'b0;
    e0 = early8_n; l0 = late8_n;
    repeat (600) tick();
    checks++; if (late8_n != l0 || if8.alarm !== 1'b0 || if8.locked !== 1'b0) begin failures++; $display("FAIL idle_nocheck late_pulses=%0d alarm=%0b locked=%0b exp=0/0/0", late8_n - l0, if8.alarm, if8.locked); end
    if8.hb_in = 1'b1;
    repeat (600) tick();
    if8.hb_in = 1'b0;
    tick();
    checks++; if ((late8_n - l0) !== 1 || (early8_n - e0) !== 0 || if8.alarm !== 1'b1) begin failures++; $display("FAIL level_one_edge late=%0d early=%0d alarm=%0b exp=1/0/1", late8_n - l0, early8_n - e0, if8.alarm); end
    checks++; if (if8.err_count !== (ERR_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL level_err got=%0d exp=%0d", if8.err_count, ERR_EN ? 1 : 0); end
  endtask

  task automatic test_err_counter();
    beat4();
    repeat (3) period4(5);
    checks++; if (if4.early !== 1'b1 || if4.err_count !== (ERR_EN ? 4'd3 : 4'd0)) begin failures++; $display("FAIL err_early3 early=%0b err=%0d exp=1/%0d", if4.early, if4.err_count, ERR_EN ? 3 : 0); end
    repeat (17) tick();
    checks++; if (if4.late !== 1'b0) begin failures++; $display("FAIL err_pre_late late=%0b exp=0", if4.late); end
    if4.clear_err = 1'b1;
    tick();
    if4.clear_err = 1'b0;
    checks++; if (if4.late !== 1'b1 || if4.alarm !== 1'b1) begin failures++; $display("FAIL err_late18 late=%0b alarm=%0b exp=1/1", if4.late, if4.alarm); end
    checks++; if (if4.err_count !== (ERR_EN ? 4'd1 : 4'd0)) begin failures++; $display("FAIL err_clear_event got=%0d exp=%0d", if4.err_count, ERR_EN ? 1 : 0); end
    beat4();
    for (int i = 1; i <= 20; i++) begin
      period4(5);
      if (i == 13) begin
        checks++; if (if4.err_count !== (ERR_EN ? 4'd14 : 4'd0)) begin failures++; $display("FAIL err_count13 got=%0d exp=%0d", if4.err_count, ERR_EN ? 14 : 0); end
      end
    end
    checks++; if (if4.early !== 1'b1 || if4.err_count !== (ERR_EN ? 4'd15 : 4'd0)) begin failures++; $display("FAIL err_saturate early=%0b err=%0d exp=1/%0d", if4.early, if4.err_count, ERR_EN ? 15 : 0); end
    tick();
    if4.clear_err = 1'b1;
    tick();
    if4.clear_err = 1'b0;
    checks++; if (if4.err_count !== 4'd0) begin failures++; $display("FAIL err_clear_alone got=%0d exp=0", if4.err_count); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_tolerance();
    test_missing_beat();
    test_reset_mid();
    test_err_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
